// File: rtl/pipe_phy_pkg.sv
// pipe_phy_pkg: shared handshake state, PowerDown codes and RxStatus codes for the PIPE loopback PHY.
// Contents: phy_state_e FSM encoding, P0..P2 PowerDown codes, RXSTAT_* status codes, lane_skew helper.
package pipe_phy_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_DETECT, ST_RATE, ST_PD_ACK} phy_state_e;
  localparam logic [3:0] P0  = 4'd0;
  localparam logic [3:0] P0S = 4'd1;
  localparam logic [3:0] P1  = 4'd2;
  localparam logic [3:0] P2  = 4'd3;
  localparam logic [2:0] RXSTAT_OK       = 3'b000;
  localparam logic [2:0] RXSTAT_DETECTED = 3'b011;
  function automatic int lane_skew(input int lane);
    return lane % 4;
  endfunction
endpackage

// File: rtl/pipe_lane_delay.sv
// pipe_lane_delay: fixed-depth shift register carrying one lane's data, K flags, valid and idle.
// Ports: clk/rst_n (async active-low), data_i/k_i/valid_i/idle_i in, data_o/k_o/valid_o/idle_o after DEPTH cycles.
// Idle resets to 1 so a freshly reset lane reads as electrically idle.
module pipe_lane_delay
#(
  parameter int W     = 32,
  parameter int KW    = 4,
  parameter int DEPTH = 2
)
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  data_i,
  input  logic [KW-1:0] k_i,
  input  logic          valid_i,
  input  logic          idle_i,
  output logic [W-1:0]  data_o,
  output logic [KW-1:0] k_o,
  output logic          valid_o,
  output logic          idle_o
);
  localparam int SW = W + KW + 2;
  localparam logic [SW-1:0] RST_VAL = SW'(1);
  logic [DEPTH-1:0][SW-1:0] pipe_q, pipe_d;
  always_comb begin
    pipe_d[0] = {data_i, k_i, valid_i, idle_i};
    for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pipe_q <= {DEPTH{RST_VAL}};
    else        pipe_q <= pipe_d;
  assign {data_o, k_o, valid_o, idle_o} = pipe_q[DEPTH-1];
endmodule

// File: rtl/pipe_loopback_phy.sv
// pipe_loopback_phy: PIPE PHY model looping TxData back to RxData and answering detect/rate/PowerDown handshakes.
// Ports: CLK, reset (async active-low); Tx* / PowerDown / Rate / rx_present in; Rx* / RxStatus / PhyStatus out.
// Build option PIPE_LANE_SKEW_EN: lane n gets (n mod 4) extra cycles of datapath delay.
module pipe_loopback_phy
  import pipe_phy_pkg::*;
#(
  parameter int LANESNUMBER   = 16,
  parameter int MAXPIPEWIDTH  = 32,
  parameter int LATENCY       = 2,
  parameter int DETECT_CYCLES = 10,
  parameter int RATE_CYCLES   = 8
)
(
  input  logic                                  CLK,
  input  logic                                  reset,
  input  logic [MAXPIPEWIDTH*LANESNUMBER-1:0]   TxData,
  input  logic [LANESNUMBER-1:0]                TxDataValid,
  input  logic [(MAXPIPEWIDTH/8)*LANESNUMBER-1:0] TxDataK,
  input  logic [LANESNUMBER-1:0]                TxElecIdle,
  input  logic [LANESNUMBER-1:0]                TxDetectRx_Loopback,
  input  logic [4*LANESNUMBER-1:0]              PowerDown,
  input  logic [3:0]                            Rate,
  input  logic [LANESNUMBER-1:0]                rx_present,
  output logic [MAXPIPEWIDTH*LANESNUMBER-1:0]   RxData,
  output logic [LANESNUMBER-1:0]                RxDataValid,
  output logic [(MAXPIPEWIDTH/8)*LANESNUMBER-1:0] RxDataK,
  output logic [LANESNUMBER-1:0]                RxValid,
  output logic [LANESNUMBER-1:0]                RxElectricalIdle,
  output logic [3*LANESNUMBER-1:0]              RxStatus,
  output logic [LANESNUMBER-1:0]                PhyStatus
);
  localparam int KW   = MAXPIPEWIDTH / 8;
  localparam int MAXC = DETECT_CYCLES > RATE_CYCLES ? DETECT_CYCLES : RATE_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;
  logic [LANESNUMBER-1:0] dly_valid, dly_idle;
  phy_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] cur_rate_q, cur_rate_d;
  logic [4*LANESNUMBER-1:0] cur_pd_q, cur_pd_d;
  logic [LANESNUMBER-1:0] det_prev_q, det_prev_d;
  logic det_pend_q, det_pend_d;
  logic [LANESNUMBER-1:0] phy_status_q, phy_status_d;
  logic [3*LANESNUMBER-1:0] rx_status_q, rx_status_d;
  logic det_edge, all_idle;
  for (genvar n = 0; n < LANESNUMBER; n++) begin : g_lane
`ifdef PIPE_LANE_SKEW_EN
    localparam int DEPTH = LATENCY + lane_skew(n);
`else
    localparam int DEPTH = LATENCY;
`endif
    pipe_lane_delay #(.W(MAXPIPEWIDTH), .KW(KW), .DEPTH(DEPTH)) u_dly (
      .clk     (CLK),
      .rst_n   (reset),
      .data_i  (TxData[n*MAXPIPEWIDTH +: MAXPIPEWIDTH]),
      .k_i     (TxDataK[n*KW +: KW]),
      .valid_i (TxDataValid[n]),
      .idle_i  (TxElecIdle[n]),
      .data_o  (RxData[n*MAXPIPEWIDTH +: MAXPIPEWIDTH]),
      .k_o     (RxDataK[n*KW +: KW]),
      .valid_o (dly_valid[n]),
      .idle_o  (dly_idle[n])
    );
  end
  assign RxDataValid      = dly_valid & rx_present;
  assign RxValid          = ~dly_idle & rx_present & {LANESNUMBER{state_q != ST_RATE}};
  assign RxElectricalIdle = dly_idle | ~rx_present;
  assign RxStatus         = rx_status_q;
  assign PhyStatus        = phy_status_q;
  assign det_edge = |(TxDetectRx_Loopback & ~det_prev_q);
  assign all_idle = &TxElecIdle;
  // Requests are compared against registered state, so anything not taken now is retried next IDLE cycle.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cur_rate_d   = cur_rate_q;
    cur_pd_d     = cur_pd_q;
    det_prev_d   = TxDetectRx_Loopback;
    det_pend_d   = det_pend_q | (det_edge && state_q != ST_IDLE);
    phy_status_d = '0;
    rx_status_d  = '0;
    case (state_q)
      ST_IDLE:
        if ((det_edge || det_pend_q) && all_idle) begin
          state_d    = ST_DETECT;
          cnt_d      = CW'(DETECT_CYCLES - 1);
          det_pend_d = 1'b0;
        end else if (Rate != cur_rate_q) begin
          state_d = ST_RATE;
          cnt_d   = CW'(RATE_CYCLES - 1);
        end else if (PowerDown != cur_pd_q) begin
          state_d = ST_PD_ACK;
        end
      ST_DETECT:
        if (cnt_q == '0) begin
          phy_status_d = '1;
          for (int i = 0; i < LANESNUMBER; i++)
            rx_status_d[3*i +: 3] = rx_present[i] ? RXSTAT_DETECTED : RXSTAT_OK;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      ST_RATE:
        if (cnt_q == '0) begin
          phy_status_d = '1;
          cur_rate_d   = Rate;
          state_d      = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      default: begin
        for (int i = 0; i < LANESNUMBER; i++)
          phy_status_d[i] = PowerDown[4*i +: 4] != cur_pd_q[4*i +: 4];
        cur_pd_d = PowerDown;
        state_d  = ST_IDLE;
      end
    endcase
  end
  always_ff @(posedge CLK or negedge reset)
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      cur_rate_q   <= '0;
      cur_pd_q     <= {LANESNUMBER{P0}};
      det_prev_q   <= '0;
      det_pend_q   <= 1'b0;
      phy_status_q <= '1;
      rx_status_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_rate_q   <= cur_rate_d;
      cur_pd_q     <= cur_pd_d;
      det_prev_q   <= det_prev_d;
      det_pend_q   <= det_pend_d;
      phy_status_q <= phy_status_d;
      rx_status_q  <= rx_status_d;
    end
endmodule

// File: tb/tb_pipe_loopback_phy.sv
// tb_pipe_loopback_phy: self-checking bench for pipe_loopback_phy (vector table, random loopback model, handshake sequences).
module tb_pipe_loopback_phy;
  localparam int L = 16, W = 32, KW = 4, LAT = 2;
  logic CLK = 1'b0;
  logic reset = 1'b0;
  logic [W*L-1:0] TxData = '0;
  logic [L-1:0] TxDataValid = '0;
  logic [KW*L-1:0] TxDataK = '0;
  logic [L-1:0] TxElecIdle = '0;
  logic [L-1:0] TxDetectRx_Loopback = '0;
  logic [4*L-1:0] PowerDown = '0;
  logic [3:0] Rate = '0;
  logic [L-1:0] rx_present = '1;
  logic [W*L-1:0] RxData;
  logic [L-1:0] RxDataValid, RxValid, RxElectricalIdle, PhyStatus;
  logic [KW*L-1:0] RxDataK;
  logic [3*L-1:0] RxStatus;
  int vectors = 0, miscompares = 0;
  always #5 CLK = ~CLK;
  pipe_loopback_phy dut (
    .CLK(CLK), .reset(reset), .TxData(TxData), .TxDataValid(TxDataValid), .TxDataK(TxDataK),
    .TxElecIdle(TxElecIdle), .TxDetectRx_Loopback(TxDetectRx_Loopback), .PowerDown(PowerDown),
    .Rate(Rate), .rx_present(rx_present), .RxData(RxData), .RxDataValid(RxDataValid),
    .RxDataK(RxDataK), .RxValid(RxValid), .RxElectricalIdle(RxElectricalIdle),
    .RxStatus(RxStatus), .PhyStatus(PhyStatus)
  );
  typedef struct {
    logic [W-1:0] data;
    logic [KW-1:0] k;
    logic valid, eidle, present, exp_dv, exp_rxvalid, exp_reidle;
  } vec_t;
  vec_t tbl[6];
  logic [W*L-1:0] h_data[64];
  logic [KW*L-1:0] h_k[64];
  logic [L-1:0] h_v[64], h_i[64];
  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic wait_phy(input int max, output int n);
    n = -1;
    for (int k = 1; k <= max; k++) begin
      tick();
      if (PhyStatus != '0) begin
        n = k;
        break;
      end
    end
  endtask
  function automatic int depth(input int n);
`ifdef PIPE_LANE_SKEW_EN
    return LAT + n % 4;
`else
    return LAT + 0 * n;
`endif
  endfunction
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int n, pulses;
    logic [W*L-1:0] e_data;
    logic [KW*L-1:0] e_k;
    logic [L-1:0] e_v, e_rv, e_i;
    logic [3*L-1:0] e_rs;
    tbl[0] = '{32'hDEADBEEF, 4'h1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{32'h12345678, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{32'hCAFEF00D, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{32'hA5A5A5A5, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{32'h00000000, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{32'hFFFFFFFF, 4'h8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    // reset sequence
    repeat (3) tick();
    chk("reset_phystatus", 512'(PhyStatus), 512'(16'hFFFF));
    chk("reset_reidle", 512'(RxElectricalIdle), 512'(16'hFFFF));
    chk("reset_rxstatus", 512'(RxStatus), 512'(0));
    chk("reset_rxvalid", 512'(RxValid), 512'(0));
    chk("reset_rxdata", 512'(RxData), 512'(0));
    reset = 1'b1;
    tick();
    chk("release_phystatus", 512'(PhyStatus), 512'(0));
    // vector table, each held long enough to cover every lane depth
    foreach (tbl[i]) begin
      TxData = {L{tbl[i].data}};
      TxDataK = {L{tbl[i].k}};
      TxDataValid = {L{tbl[i].valid}};
      TxElecIdle = {L{tbl[i].eidle}};
      rx_present = {L{tbl[i].present}};
      repeat (6) tick();
      chk($sformatf("tbl%0d_rxdata", i), 512'(RxData), 512'({L{tbl[i].data}}));
      chk($sformatf("tbl%0d_rxdatak", i), 512'(RxDataK), 512'({L{tbl[i].k}}));
      chk($sformatf("tbl%0d_rxdv", i), 512'(RxDataValid), 512'({L{tbl[i].exp_dv}}));
      chk($sformatf("tbl%0d_rxvalid", i), 512'(RxValid), 512'({L{tbl[i].exp_rxvalid}}));
      chk($sformatf("tbl%0d_reidle", i), 512'(RxElectricalIdle), 512'({L{tbl[i].exp_reidle}}));
    end
    // single-word loopback latency on lane 3
    TxElecIdle = '0; rx_present = '1; TxData = '0; TxDataValid = '0; TxDataK = '0;
    repeat (6) tick();
    TxData[3*W +: W] = 32'hDEADBEEF;
    TxDataValid[3] = 1'b1;
    n = -1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      TxData = '0;
      TxDataValid = '0;
      if (RxDataValid[3]) begin
        n = k;
        chk("loop_lane3_data", 512'(RxData[3*W +: W]), 512'(32'hDEADBEEF));
        break;
      end
    end
    chk("loop_lane3_latency", 512'(n), 512'(depth(3)));
    // random streaming against a history-based model
    for (int j = 0; j < 64; j++) begin
      for (int l = 0; l < L; l++) TxData[l*W +: W] = $urandom;
      TxDataK = {$urandom, $urandom};
      TxDataValid = 16'($urandom);
      TxElecIdle = 16'($urandom);
      rx_present = 16'($urandom);
      h_data[j] = TxData; h_k[j] = TxDataK; h_v[j] = TxDataValid; h_i[j] = TxElecIdle;
      #1;
      if (j >= 8) begin
        for (int l = 0; l < L; l++) begin
          n = j - depth(l);
          e_data[l*W +: W] = h_data[n][l*W +: W];
          e_k[l*KW +: KW] = h_k[n][l*KW +: KW];
          e_v[l] = h_v[n][l] & rx_present[l];
          e_rv[l] = ~h_i[n][l] & rx_present[l];
          e_i[l] = h_i[n][l] | ~rx_present[l];
        end
        chk($sformatf("rnd%0d_rxdata", j), 512'(RxData), 512'(e_data));
        chk($sformatf("rnd%0d_rxdatak", j), 512'(RxDataK), 512'(e_k));
        chk($sformatf("rnd%0d_rxdv", j), 512'(RxDataValid), 512'(e_v));
        chk($sformatf("rnd%0d_rxvalid", j), 512'(RxValid), 512'(e_rv));
        chk($sformatf("rnd%0d_reidle", j), 512'(RxElectricalIdle), 512'(e_i));
        chk($sformatf("rnd%0d_phystatus", j), 512'(PhyStatus), 512'(0));
      end
      tick();
    end
    // receiver detect
    TxElecIdle = '1; rx_present = 16'h00FF; TxDetectRx_Loopback = '0; TxDataValid = '0;
    repeat (2) tick();
    TxDetectRx_Loopback = 16'h0001;
    tick();
    wait_phy(20, n);
    for (int l = 0; l < L; l++) e_rs[3*l +: 3] = l < 8 ? 3'b011 : 3'b000;
    chk("detect_cycles", 512'(n), 512'(10));
    chk("detect_phystatus", 512'(PhyStatus), 512'(16'hFFFF));
    chk("detect_rxstatus", 512'(RxStatus), 512'(e_rs));
    tick();
    chk("detect_after_phystatus", 512'(PhyStatus), 512'(0));
    chk("detect_after_rxstatus", 512'(RxStatus), 512'(0));
    TxDetectRx_Loopback = '0;
    // rate change while streaming
    TxElecIdle = '0; rx_present = '1; TxDataValid = '1;
    repeat (6) tick();
    chk("stream_rxvalid", 512'(RxValid), 512'(16'hFFFF));
    Rate = 4'd1;
    tick();
    chk("rate_rxvalid_low0", 512'(RxValid), 512'(0));
    n = -1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (PhyStatus != '0) begin
        n = k;
        break;
      end
      chk($sformatf("rate_rxvalid_low%0d", k), 512'(RxValid), 512'(0));
    end
    chk("rate_cycles", 512'(n), 512'(8));
    chk("rate_phystatus", 512'(PhyStatus), 512'(16'hFFFF));
    chk("rate_rxvalid_back", 512'(RxValid), 512'(16'hFFFF));
    tick();
    chk("rate_after_phystatus", 512'(PhyStatus), 512'(0));
    // simultaneous rate and PowerDown request
    Rate = 4'd2;
    PowerDown[3:0] = 4'd2;
    tick();
    wait_phy(12, n);
    chk("simul_rate_cycles", 512'(n), 512'(8));
    chk("simul_rate_phystatus", 512'(PhyStatus), 512'(16'hFFFF));
    tick();
    chk("simul_gap_phystatus", 512'(PhyStatus), 512'(0));
    tick();
    chk("simul_pd_phystatus", 512'(PhyStatus), 512'(16'h0001));
    tick();
    chk("simul_pd_after", 512'(PhyStatus), 512'(0));
    // reset in the middle of a detect handshake
    TxElecIdle = '1; TxDetectRx_Loopback = '0;
    tick();
    TxDetectRx_Loopback = 16'h8000;
    tick();
    repeat (4) tick();
    reset = 1'b0;
    #1;
    chk("midrst_phystatus", 512'(PhyStatus), 512'(16'hFFFF));
    chk("midrst_rxstatus", 512'(RxStatus), 512'(0));
    chk("midrst_reidle", 512'(RxElectricalIdle), 512'(16'hFFFF));
    chk("midrst_rxvalid", 512'(RxValid), 512'(0));
    chk("midrst_rxdv", 512'(RxDataValid), 512'(0));
    chk("midrst_rxdata", 512'(RxData), 512'(0));
    TxDetectRx_Loopback = '0; Rate = '0; PowerDown = '0;
    repeat (2) tick();
    reset = 1'b1;
    pulses = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (PhyStatus != '0) pulses++;
    end
    chk("midrst_no_pulse", 512'(pulses), 512'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
